// File: rtl/spi_cmd_gen_pkg.sv
// Shared definitions for the SPI command generator: parameter defaults,
// FSM state encoding and a sizing helper for the debounce counters.
package spi_cmd_gen_pkg;

  localparam int DATA_W_DEF       = 8;
  localparam int SYNC_STAGES_DEF  = 2;
  localparam int DEBOUNCE_CYC_DEF = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DONE = 2'd2
  } cmd_state_t;

  // Bits needed to hold 0 .. cyc-1; never narrower than one bit.
  function automatic int dbnc_cnt_w(input int cyc);
    return (cyc <= 2) ? 1 : $clog2(cyc);
  endfunction

endpackage

// File: rtl/spi_cmd_gen_if.sv
// Request channel between the command generator and the SPI core:
// valid/ready word transfer plus the core's frame-complete pulse.
interface spi_cmd_gen_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              spi_done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  spi_done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output spi_done
  );

endinterface

// File: rtl/spi_cmd_gen_btn_debounce.sv
// Push-button conditioner: multi-flop synchroniser, stable-count debounce and
// a registered single-cycle pulse on each accepted press (0->1 level change).
module btn_debounce
  import spi_cmd_gen_pkg::*;
#(
  parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic a_rst_n,
  input  logic raw,
  output logic rise
);

  localparam int                CNT_W    = dbnc_cnt_w(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;
  logic                   level_d_q;
  logic                   rise_q;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = rise_q;

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      level_d_q <= 1'b0;
      rise_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], raw};
      level_d_q <= level_q;
      rise_q    <= level_q & ~level_d_q;
      // Any cycle where s agrees with the accepted level restarts the count,
      // so a glitch shorter than DEBOUNCE_CYC cycles never reaches CNT_LAST.
      if (s != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= s;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/spi_cmd_gen.sv
// Upstream request stage for the SPI master: button conditioning, data counter
// and a three-state request FSM that sends one word per press to the SPI core.
module spi_cmd_gen
  import spi_cmd_gen_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic                clk_100,
  input  logic                a_rst_n,
  input  logic                button_0,
  input  logic                button_1,
  spi_cmd_gen_if.master       spi,
  output logic [DATA_W-1:0]   data_cnt,
  output logic                busy
);

  logic              inc_pulse;
  logic              send_pulse;
  logic [DATA_W-1:0] cnt_q;
  cmd_state_t        state_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_valid_q;
  logic              busy_q;

  function automatic logic [DATA_W-1:0] wrap_inc(input logic [DATA_W-1:0] v);
    return v + 1'b1;
  endfunction

  btn_debounce #(
    .SYNC_STAGES  (SYNC_STAGES),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_dbnc_inc (
    .clk     (clk_100),
    .a_rst_n (a_rst_n),
    .raw     (button_0),
    .rise    (inc_pulse)
  );

  btn_debounce #(
    .SYNC_STAGES  (SYNC_STAGES),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_dbnc_send (
    .clk     (clk_100),
    .a_rst_n (a_rst_n),
    .raw     (button_1),
    .rise    (send_pulse)
  );

  // Counter runs independently of the FSM so presses are never lost while busy.
  always_ff @(posedge clk_100 or negedge a_rst_n) begin
    if (!a_rst_n) begin
      cnt_q <= '0;
    end else if (inc_pulse) begin
      cnt_q <= wrap_inc(cnt_q);
    end
  end

  // tx_data samples cnt_q before any same-cycle increment lands, so a
  // simultaneous inc+send transmits the pre-increment value.
  always_ff @(posedge clk_100 or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (send_pulse) begin
            tx_data_q  <= cnt_q;
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (tx_valid_q && spi.tx_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (spi.spi_done) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign spi.tx_data  = tx_data_q;
  assign spi.tx_valid = tx_valid_q;
  assign data_cnt     = cnt_q;
  assign busy         = busy_q;

  a_valid_stable : assert property (
    @(posedge clk_100) disable iff (!a_rst_n)
      (tx_valid_q && !spi.tx_ready) |=> (tx_valid_q && $stable(tx_data_q))
  );

  a_valid_implies_busy : assert property (
    @(posedge clk_100) disable iff (!a_rst_n)
      tx_valid_q |-> busy_q
  );

endmodule

// File: tb/tb_spi_cmd_gen.sv
// Randomised scenario bench for spi_cmd_gen with a behavioural press/send model.
module tb_spi_cmd_gen;

  localparam int DATA_W       = 8;
  localparam int SYNC_STAGES  = 2;
  localparam int DEBOUNCE_CYC = 4;

  logic              clk;
  logic              a_rst_n;
  logic              button_0;
  logic              button_1;
  logic [DATA_W-1:0] data_cnt;
  logic              busy;

  int checks;
  int errors;
  int exp_cnt;

  spi_cmd_gen_if #(.DATA_W(DATA_W)) spi_if ();

  spi_cmd_gen #(
    .DATA_W       (DATA_W),
    .SYNC_STAGES  (SYNC_STAGES),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) dut (
    .clk_100  (clk),
    .a_rst_n  (a_rst_n),
    .button_0 (button_0),
    .button_1 (button_1),
    .spi      (spi_if),
    .data_cnt (data_cnt),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive raw buttons high for hold cycles then low for gap cycles,
  // counting how many sampled cycles showed tx_valid.
  task automatic run_press(input logic b0, input logic b1, input int hold,
                           input int gap, output int vld_cycles);
    vld_cycles = 0;
    button_0 = b0;
    button_1 = b1;
    for (int i = 0; i < hold + gap; i++) begin
      if (i == hold) begin
        button_0 = 1'b0;
        button_1 = 1'b0;
      end
      @(negedge clk);
      if (spi_if.tx_valid === 1'b1) vld_cycles++;
    end
    button_0 = 1'b0;
    button_1 = 1'b0;
  endtask

  // One full transaction: press send (optionally with inc), hold ready low
  // ready_delay cycles, handshake, wait done_delay cycles, pulse spi_done.
  task automatic send_and_check(input int ready_delay, input int done_delay,
                                input bit done_in_req, input bit with_inc);
    logic [DATA_W-1:0] word;
    bit seen;
    word = exp_cnt[DATA_W-1:0];
    if (with_inc) exp_cnt = (exp_cnt + 1) % 256;
    seen = 1'b0;
    spi_if.tx_ready = (ready_delay == 0);
    button_1 = 1'b1;
    button_0 = with_inc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 6) begin
        button_1 = 1'b0;
        button_0 = 1'b0;
      end
      if (spi_if.tx_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    button_1 = 1'b0;
    button_0 = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL send_timeout: tx_valid never rose, required 1 within 40 cycles");
    end else begin
      checks++;
      if (spi_if.tx_data !== word) begin
        errors++;
        $display("FAIL send_word: tx_data=%h required %h", spi_if.tx_data, word);
      end
      checks++;
      if (busy !== 1'b1 || data_cnt !== exp_cnt[DATA_W-1:0]) begin
        errors++;
        $display("FAIL send_busy_cnt: busy=%b data_cnt=%h required 1 %h",
                 busy, data_cnt, exp_cnt[DATA_W-1:0]);
      end
      for (int d = 0; d < ready_delay; d++) begin
        if (done_in_req && d == 0) spi_if.spi_done = 1'b1;
        @(negedge clk);
        spi_if.spi_done = 1'b0;
        checks++;
        if (spi_if.tx_valid !== 1'b1 || spi_if.tx_data !== word) begin
          errors++;
          $display("FAIL send_hold: tx_valid=%b tx_data=%h required 1 %h",
                   spi_if.tx_valid, spi_if.tx_data, word);
        end
      end
      spi_if.tx_ready = 1'b1;
      @(negedge clk);
      spi_if.tx_ready = 1'b0;
      checks++;
      if (spi_if.tx_valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL send_drop: tx_valid=%b busy=%b required 0 1",
                 spi_if.tx_valid, busy);
      end
      for (int d = 0; d < done_delay; d++) begin
        @(negedge clk);
        checks++;
        if (spi_if.tx_valid !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL wait_done: tx_valid=%b busy=%b required 0 1",
                   spi_if.tx_valid, busy);
        end
      end
      spi_if.spi_done = 1'b1;
      @(negedge clk);
      spi_if.spi_done = 1'b0;
      checks++;
      if (busy !== 1'b0 || spi_if.tx_valid !== 1'b0) begin
        errors++;
        $display("FAIL done_idle: busy=%b tx_valid=%b required 0 0",
                 busy, spi_if.tx_valid);
      end
    end
    spi_if.tx_ready = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0;
    spi_if.tx_ready = 1'b0;
    spi_if.spi_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      button_0 = 1'($urandom_range(0, 1));
      button_1 = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (spi_if.tx_valid !== 1'b0 || busy !== 1'b0 ||
          data_cnt !== 8'h00 || spi_if.tx_data !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold: valid=%b busy=%b cnt=%h data=%h required 0 0 00 00",
                 spi_if.tx_valid, busy, data_cnt, spi_if.tx_data);
      end
    end
    button_0 = 1'b0;
    button_1 = 1'b0;
    a_rst_n  = 1'b1;
    exp_cnt  = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (data_cnt !== 8'h00 || spi_if.tx_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_release: cnt=%h valid=%b busy=%b required 00 0 0",
                 data_cnt, spi_if.tx_valid, busy);
      end
    end
  endtask

  task automatic test_glitch();
    int vld;
    for (int g = 0; g < 4; g++) begin
      run_press(1'b1, 1'b0, $urandom_range(1, DEBOUNCE_CYC - 1), 10, vld);
      checks++;
      if (data_cnt !== exp_cnt[DATA_W-1:0]) begin
        errors++;
        $display("FAIL glitch_reject: data_cnt=%h required %h", data_cnt, exp_cnt[DATA_W-1:0]);
      end
    end
    run_press(1'b1, 1'b0, 10, 12, vld);
    exp_cnt = (exp_cnt + 1) % 256;
    repeat (10) @(negedge clk);
    checks++;
    if (data_cnt !== exp_cnt[DATA_W-1:0]) begin
      errors++;
      $display("FAIL glitch_accept: data_cnt=%h required %h", data_cnt, exp_cnt[DATA_W-1:0]);
    end
  endtask

  task automatic test_wrap();
    int vld;
    int n;
    n = 256 - exp_cnt;
    for (int i = 0; i < n; i++) begin
      run_press(1'b1, 1'b0, $urandom_range(DEBOUNCE_CYC, DEBOUNCE_CYC + 4), 10, vld);
      exp_cnt = (exp_cnt + 1) % 256;
    end
    checks++;
    if (data_cnt !== 8'h00 || exp_cnt != 0) begin
      errors++;
      $display("FAIL wrap_zero: data_cnt=%h required 00", data_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      run_press(1'b1, 1'b0, $urandom_range(DEBOUNCE_CYC, DEBOUNCE_CYC + 4), 10, vld);
      exp_cnt = (exp_cnt + 1) % 256;
    end
    checks++;
    if (data_cnt !== exp_cnt[DATA_W-1:0]) begin
      errors++;
      $display("FAIL wrap_three: data_cnt=%h required %h", data_cnt, exp_cnt[DATA_W-1:0]);
    end
  endtask

  task automatic test_send();
    int vld;
    while (exp_cnt != 5) begin
      run_press(1'b1, 1'b0, DEBOUNCE_CYC + 2, 10, vld);
      exp_cnt = (exp_cnt + 1) % 256;
    end
    checks++;
    if (data_cnt !== 8'h05) begin
      errors++;
      $display("FAIL send_setup: data_cnt=%h required 05", data_cnt);
    end
    send_and_check(5, 4, 1'b0, 1'b0);
  endtask

  task automatic test_drop_snapshot();
    int vld;
    bit seen;
    seen = 1'b0;
    spi_if.tx_ready = 1'b1;
    button_1 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 6) button_1 = 1'b0;
      if (spi_if.tx_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    button_1 = 1'b0;
    checks++;
    if (!seen || spi_if.tx_data !== exp_cnt[DATA_W-1:0]) begin
      errors++;
      $display("FAIL drop_first: seen=%b tx_data=%h required 1 %h",
               seen, spi_if.tx_data, exp_cnt[DATA_W-1:0]);
    end
    @(negedge clk);
    spi_if.tx_ready = 1'b0;
    repeat (10) @(negedge clk);
    run_press(1'b1, 1'b1, 6, 14, vld);
    exp_cnt = (exp_cnt + 1) % 256;
    checks++;
    if (vld !== 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_send: tx_valid cycles=%0d busy=%b required 0 1", vld, busy);
    end
    checks++;
    if (data_cnt !== exp_cnt[DATA_W-1:0]) begin
      errors++;
      $display("FAIL drop_inc: data_cnt=%h required %h", data_cnt, exp_cnt[DATA_W-1:0]);
    end
    spi_if.spi_done = 1'b1;
    @(negedge clk);
    spi_if.spi_done = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_done: busy=%b required 0", busy);
    end
    repeat (4) @(negedge clk);
    send_and_check($urandom_range(0, 4), $urandom_range(0, 4), 1'b0, 1'b0);
    send_and_check($urandom_range(0, 4), $urandom_range(0, 4), 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int vld;
    for (int k = 0; k < 8; k++) begin
      for (int p = $urandom_range(0, 3); p > 0; p--) begin
        if ($urandom_range(0, 3) == 0) begin
          run_press(1'b1, 1'b0, $urandom_range(1, DEBOUNCE_CYC - 1), 10, vld);
        end else begin
          run_press(1'b1, 1'b0, $urandom_range(DEBOUNCE_CYC, DEBOUNCE_CYC + 5), 10, vld);
          exp_cnt = (exp_cnt + 1) % 256;
        end
      end
      checks++;
      if (data_cnt !== exp_cnt[DATA_W-1:0]) begin
        errors++;
        $display("FAIL b2b_cnt: data_cnt=%h required %h", data_cnt, exp_cnt[DATA_W-1:0]);
      end
      send_and_check($urandom_range(0, 6), $urandom_range(0, 5),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_req();
    bit seen;
    seen = 1'b0;
    spi_if.tx_ready = 1'b0;
    button_1 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 6) button_1 = 1'b0;
      if (spi_if.tx_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    button_1 = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL midreq_setup: tx_valid=%b required 1", spi_if.tx_valid);
    end
    #2 a_rst_n = 1'b0;
    #1;
    checks++;
    if (spi_if.tx_valid !== 1'b0 || busy !== 1'b0 || data_cnt !== 8'h00) begin
      errors++;
      $display("FAIL midreq_async: valid=%b busy=%b cnt=%h required 0 0 00",
               spi_if.tx_valid, busy, data_cnt);
    end
    @(negedge clk);
    a_rst_n = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (spi_if.tx_valid !== 1'b0 || busy !== 1'b0 || data_cnt !== 8'h00) begin
        errors++;
        $display("FAIL midreq_release: valid=%b busy=%b cnt=%h required 0 0 00",
                 spi_if.tx_valid, busy, data_cnt);
      end
    end
    send_and_check(2, 1, 1'b0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_cnt  = 0;
    a_rst_n  = 1'b0;
    button_0 = 1'b0;
    button_1 = 1'b0;
    spi_if.tx_ready = 1'b0;
    spi_if.spi_done = 1'b0;
    @(negedge clk);
    test_reset();
    test_glitch();
    test_wrap();
    test_send();
    test_drop_snapshot();
    test_back_to_back();
    test_reset_mid_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
